// File: rtl/wb_queue_if.sv
// wb_queue_if: bundles the MEM-side push handshake and the register-file
// write port of the writeback queue.
//   master : the producer and write-port side. It drives in_* and wb_stall,
//            and it observes in_ready, wb_en, wb_dest, wb_value, pending and count.
//   slave  : the queue itself.
interface wb_queue_if #(
  parameter int depth       = 15,
  parameter int lengt       = 32,
  parameter int clog2_depth = $clog2(depth),
  parameter int fifo_depth  = 4
);
  logic                            in_valid;
  logic                            in_ready;
  logic                            in_wb_en;
  logic                            in_mem_r_en;
  logic [clog2_depth-1:0]          in_dest;
  logic [lengt-1:0]                in_alu_result;
  logic [lengt-1:0]                in_mem_result;
  logic                            wb_stall;
  logic                            wb_en;
  logic [clog2_depth-1:0]          wb_dest;
  logic [lengt-1:0]                wb_value;
  logic [depth-1:0]                pending;
  logic [$clog2(fifo_depth):0]     count;

  modport master (
    output in_valid, in_wb_en, in_mem_r_en, in_dest, in_alu_result, in_mem_result, wb_stall,
    input  in_ready, wb_en, wb_dest, wb_value, pending, count
  );

  modport slave (
    input  in_valid, in_wb_en, in_mem_r_en, in_dest, in_alu_result, in_mem_result, wb_stall,
    output in_ready, wb_en, wb_dest, wb_value, pending, count
  );
endinterface

// File: rtl/wb_queue.sv
// wb_queue: an in-order writeback buffer that sits between MEM/WB and the register file.
//   clk, rst : clock, and an asynchronous active-high reset that drops all entries.
//   bus      : a wb_queue_if.slave port.
//              - Push side: in_valid/in_ready handshake. When in_wb_en=1 the entry
//                {in_dest, ALU result or load data} is enqueued. Load data is chosen
//                when in_mem_r_en=1.
//              - Write side: wb_en, wb_dest and wb_value are driven from the queue head.
//                The write side is held while wb_stall=1.
//              - Status: pending is the per-register mask of buffered destinations.
//                count is the number of occupied entries.
module wb_queue #(
  parameter int depth       = 15,
  parameter int lengt       = 32,
  parameter int clog2_depth = $clog2(depth),
  parameter int fifo_depth  = 4
) (
  input  logic          clk,
  input  logic          rst,
  wb_queue_if.slave     bus
);
  localparam int PW = $clog2(fifo_depth);
  localparam int CW = PW + 1;

  logic [clog2_depth-1:0] dest_mem  [fifo_depth];
  logic [lengt-1:0]       value_mem [fifo_depth];
  logic [fifo_depth-1:0]  valid_reg;
  logic [PW-1:0]          rd_ptr_reg;
  logic [PW-1:0]          wr_ptr_reg;
  logic [CW-1:0]          count_reg;

  logic not_empty;
  logic pop;
  logic enq;

  assign not_empty = (count_reg != '0);
  assign pop       = not_empty & ~bus.wb_stall;
  // A pop frees the head slot during the same edge, so a full queue can still
  // accept an entry while it is draining.
  assign bus.in_ready = (count_reg < CW'(fifo_depth)) | pop;
  assign enq       = bus.in_valid & bus.in_ready & bus.in_wb_en;

  assign bus.wb_en    = pop;
  assign bus.wb_dest  = not_empty ? dest_mem[rd_ptr_reg]  : '0;
  assign bus.wb_value = not_empty ? value_mem[rd_ptr_reg] : '0;
  assign bus.count    = count_reg;

  // Payload storage needs no reset, because valid_reg and count_reg gate every use of it.
  always_ff @(posedge clk) begin
    if (enq) begin
      dest_mem[wr_ptr_reg]  <= bus.in_dest;
      value_mem[wr_ptr_reg] <= bus.in_mem_r_en ? bus.in_mem_result : bus.in_alu_result;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg  <= '0;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (pop) begin
        valid_reg[rd_ptr_reg] <= 1'b0;
        rd_ptr_reg            <= rd_ptr_reg + PW'(1);
      end
      // This assignment comes after the pop clear, so that when the queue is full
      // and pushes and pops in the same cycle, the reused slot ends up valid.
      if (enq) begin
        valid_reg[wr_ptr_reg] <= 1'b1;
        wr_ptr_reg            <= wr_ptr_reg + PW'(1);
      end
      case ({enq, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Each register bit ORs its matches over the valid entries. A destination
  // of depth or higher matches no bit, so such an entry sets no pending bit.
  for (genvar gi = 0; gi < depth; gi++) begin : g_pend
    logic [fifo_depth-1:0] hit;
    for (genvar gj = 0; gj < fifo_depth; gj++) begin : g_ent
      assign hit[gj] = valid_reg[gj] && (dest_mem[gj] == clog2_depth'(gi));
    end
    assign bus.pending[gi] = |hit;
  end
endmodule

// File: tb/tb_wb_queue.sv
module tb_wb_queue;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_queue_if #(.depth(15), .lengt(32), .fifo_depth(4)) bus ();

  wb_queue #(.depth(15), .lengt(32), .fifo_depth(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [3:0]  d;
    logic [31:0] v;
  } ent_t;

  ent_t q[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // The bench drives one cycle here. It is entered just after a posedge.
  // At the negedge it checks every output against the queue model. Then it
  // updates the model with what the coming posedge does.
  task automatic step(input bit v, input bit we, input bit mr, input logic [3:0] d,
                      input logic [31:0] a, input logic [31:0] m, input bit st);
    int          n;
    bit          e_en;
    bit          e_rdy;
    logic [14:0] e_pend;
    ent_t        e;
    bus.in_valid      = v;
    bus.in_wb_en      = we;
    bus.in_mem_r_en   = mr;
    bus.in_dest       = d;
    bus.in_alu_result = a;
    bus.in_mem_result = m;
    bus.wb_stall      = st;
    @(negedge clk);
    n      = q.size();
    e_en   = (n != 0) && !st;
    e_rdy  = (n < 4) || e_en;
    e_pend = '0;
    foreach (q[k]) if (q[k].d < 15) e_pend[q[k].d] = 1'b1;
    chk("wb_en",    64'(bus.wb_en),    64'(e_en));
    chk("wb_dest",  64'(bus.wb_dest),  (n != 0) ? 64'(q[0].d) : 64'(0));
    chk("wb_value", 64'(bus.wb_value), (n != 0) ? 64'(q[0].v) : 64'(0));
    chk("count",    64'(bus.count),    64'(n));
    chk("in_ready", 64'(bus.in_ready), 64'(e_rdy));
    chk("pending",  64'(bus.pending),  64'(e_pend));
    if (e_en) void'(q.pop_front());
    if (v && e_rdy && we) begin
      e.d = d;
      e.v = mr ? m : a;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 4'd0, 32'd0, 32'd0, 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 0; bus.in_wb_en = 0; bus.in_mem_r_en = 0; bus.in_dest = '0;
    bus.in_alu_result = '0; bus.in_mem_result = '0; bus.wb_stall = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_count", 64'(bus.count), 64'(0));
    chk("rst_wb_en", 64'(bus.wb_en), 64'(0));
    chk("rst_ready", 64'(bus.in_ready), 64'(1));

    // Single ALU write.
    step(1, 1, 0, 4'd3, 32'h1234, 32'h0, 0);
    chk("alu_dest",  64'(bus.wb_dest), 64'(3));
    chk("alu_value", 64'(bus.wb_value), 64'h1234);
    chk("alu_pend3", 64'(bus.pending[3]), 64'(1));
    idle(2);

    // Load data select.
    step(1, 1, 1, 4'd5, 32'hAAAA, 32'hDEADBEEF, 0);
    chk("load_sel", 64'(bus.wb_value), 64'hDEADBEEF);
    idle(2);

    // Stalled fill, then drain in order.
    for (int i = 1; i <= 4; i++) step(1, 1, 0, 4'(i), 32'(i * 16), 32'h0, 1);
    chk("full_count", 64'(bus.count), 64'(4));
    chk("full_ready", 64'(bus.in_ready), 64'(0));
    chk("full_pend",  64'(bus.pending), 64'h001E);
    idle(5);

    // Full, with a push and a pop in the same cycle.
    for (int i = 8; i <= 11; i++) step(1, 1, 0, 4'(i), 32'(i), 32'h0, 1);
    step(1, 1, 0, 4'd7, 32'h77, 32'h0, 0);
    chk("pp_count", 64'(bus.count), 64'(4));
    idle(5);

    // Push with in_wb_en=0, duplicate destinations, and an out-of-range destination.
    step(1, 0, 0, 4'd6, 32'h66, 32'h0, 0);
    chk("nowb_count", 64'(bus.count), 64'(0));
    step(1, 1, 0, 4'd2, 32'h21, 32'h0, 1);
    step(1, 1, 0, 4'd2, 32'h22, 32'h0, 1);
    step(1, 1, 0, 4'd15, 32'hFF, 32'h0, 1);
    chk("dup_pend", 64'(bus.pending), 64'h0004);
    idle(5);

    // Asynchronous reset while the queue holds 3 entries.
    for (int i = 0; i < 3; i++) step(1, 1, 0, 4'(i + 9), 32'(i), 32'h0, 1);
    bus.wb_stall = 0;
    #2 rst = 1'b1;
    #1;
    chk("arst_count", 64'(bus.count), 64'(0));
    chk("arst_wb_en", 64'(bus.wb_en), 64'(0));
    chk("arst_pend",  64'(bus.pending), 64'(0));
    chk("arst_ready", 64'(bus.in_ready), 64'(1));
    q.delete();
    @(posedge clk);
    #1 rst = 1'b0;

    // Random traffic, checked every cycle against the model.
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) != 0),
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
           $urandom, $urandom, 1'($urandom_range(0, 9) < 3));
    idle(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
